// File: rtl/cla_pipe_pkg.sv
// cla_pipe_pkg: shared constants and parameter helpers for the pipelined CLA adder/subtractor
package cla_pipe_pkg;

    localparam int GROUP_W = 4;

    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? width / stages : GROUP_W;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= 8) && (width > 0) && (width % (GROUP_W * stages) == 0);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// cla_seg: combinational SEG-bit carry-lookahead adder built from 4-bit groups with group lookahead
module cla_seg
    import cla_pipe_pkg::*;
#(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_ci,
    output logic [SEG-1:0] o_s,
    output logic           o_co
);
    localparam int NG = SEG / GROUP_W;

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG-1:0] w_c;
    logic [NG-1:0]  w_gg;
    logic [NG-1:0]  w_gp;
    logic [NG:0]    w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // group generate/propagate feed the group carry chain; bit carries are expanded inside each group
    always_comb begin
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        w_gc[0] = i_ci;
        for (int j = 0; j < NG; j++) begin
            int o;
            o = j * GROUP_W;
            w_gp[j]    = &w_p[o +: 4];
            w_gg[j]    = w_g[o+3] | (w_p[o+3] & w_g[o+2]) | (&w_p[o+2 +: 2] & w_g[o+1]) | (&w_p[o+1 +: 3] & w_g[o]);
            w_gc[j+1]  = w_gg[j] | (w_gp[j] & w_gc[j]);
            w_c[o]     = w_gc[j];
            w_c[o+1]   = w_g[o] | (w_p[o] & w_gc[j]);
            w_c[o+2]   = w_g[o+1] | (w_p[o+1] & w_g[o]) | (&w_p[o +: 2] & w_gc[j]);
            w_c[o+3]   = w_g[o+2] | (w_p[o+2] & w_g[o+1]) | (&w_p[o+1 +: 2] & w_g[o]) | (&w_p[o +: 3] & w_gc[j]);
        end
    end

    assign o_s  = w_p ^ w_c;
    assign o_co = w_gc[NG];

endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor with valid/ready stall control
// Defining CLA_PIPE_OVF_EN adds the registered signed-overflow output o_ovf.
module cla_pipe_addsub
    import cla_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             o_ovf
`endif
);
    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_illegal
        $error("cla_pipe_addsub: WIDTH=%0d must be a multiple of 4*STAGES and STAGES=%0d must be 1..8", WIDTH, STAGES);
    end

    logic             w_stall;
    logic [WIDTH-1:0] w_a  [STAGES];
    logic [WIDTH-1:0] w_b  [STAGES];
    logic [WIDTH-1:0] w_ps [STAGES+1];
    logic [STAGES:0]  w_c;
    logic [STAGES:0]  w_v;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic             r_v;
    logic [WIDTH-1:0] r_os;
    logic             r_oco;
    logic             r_ov;

    assign w_stall     = r_ov && !i_out_ready;
    assign o_in_ready  = !w_stall;
    assign o_out_valid = r_ov;
    assign o_s         = r_os;
    assign o_co        = r_oco;

    // input stage: capture A, B pre-inverted for subtraction, and the effective carry-in
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v <= 1'b0;
            r_a <= '0;
            r_b <= '0;
            r_c <= 1'b0;
        end else if (!w_stall) begin
            r_v <= i_in_valid;
            if (i_in_valid) begin
                r_a <= i_a;
                r_b <= i_b ^ {WIDTH{i_sub}};
                r_c <= i_sub | i_ci;
            end
        end
    end

    assign w_a[0]  = r_a;
    assign w_b[0]  = r_b;
    assign w_c[0]  = r_c;
    assign w_v[0]  = r_v;
    assign w_ps[0] = '0;

`ifdef CLA_PIPE_OVF_EN
    logic w_ovf;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   w_sum;
        logic             w_co;
        logic [WIDTH-1:0] w_ns;
        logic [WIDTH-1:0] r_ps;
        logic             r_pc;
        logic             r_pv;

        cla_seg #(.SEG(SEG)) u_seg (
            .i_a  (w_a[k][k*SEG +: SEG]),
            .i_b  (w_b[k][k*SEG +: SEG]),
            .i_ci (w_c[k]),
            .o_s  (w_sum),
            .o_co (w_co)
        );

        // merge this segment's sum into the deskewed partial result
        always_comb begin
            w_ns = w_ps[k];
            w_ns[k*SEG +: SEG] = w_sum;
        end

        // segment register: partial sum, segment carry-out and the beat's valid bit
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_pv <= 1'b0;
                r_ps <= '0;
                r_pc <= 1'b0;
            end else if (!w_stall) begin
                r_pv <= w_v[k];
                if (w_v[k]) begin
                    r_ps <= w_ns;
                    r_pc <= w_co;
                end
            end
        end

        assign w_ps[k+1] = r_ps;
        assign w_c[k+1]  = r_pc;
        assign w_v[k+1]  = r_pv;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] r_sa;
            logic [WIDTH-1:0] r_sb;

            // skew registers carry the operands forward to the stage that still needs their upper bits
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_sa <= '0;
                    r_sb <= '0;
                end else if (!w_stall && w_v[k]) begin
                    r_sa <= w_a[k];
                    r_sb <= w_b[k];
                end
            end

            assign w_a[k+1] = r_sa;
            assign w_b[k+1] = r_sb;
        end

`ifdef CLA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;

            // carry into the MSB is recovered from the operand and sum MSBs, then XORed with carry-out
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n)
                    r_ovf <= 1'b0;
                else if (!w_stall && w_v[k])
                    r_ovf <= w_a[k][WIDTH-1] ^ w_b[k][WIDTH-1] ^ w_sum[SEG-1] ^ w_co;
            end

            assign w_ovf = r_ovf;
        end
`endif
    end

    // output register: holds the aligned result until the consumer takes it
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ov  <= 1'b0;
            r_os  <= '0;
            r_oco <= 1'b0;
        end else if (!w_stall) begin
            r_ov <= w_v[STAGES];
            if (w_v[STAGES]) begin
                r_os  <= w_ps[STAGES];
                r_oco <= w_c[STAGES];
            end
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic r_oovf;

    // overflow flag travels with the result in the output register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_oovf <= 1'b0;
        else if (!w_stall && w_v[STAGES])
            r_oovf <= w_ovf;
    end

    assign o_ovf = r_oovf;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: directed self-checking bench for three configurations of cla_pipe_addsub
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;

    logic        rdy2, ov2, co2;
    logic [31:0] s2;
    logic        rdy4, ov4, co4;
    logic [63:0] s4;
    logic        rdy1, ov1, co1;
    logic [31:0] s1;
`ifdef CLA_PIPE_OVF_EN
    logic        ovf2, ovf4, ovf1;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy2),
        .i_a(a), .i_b(b), .i_ci(ci), .i_sub(sub),
        .o_out_valid(ov2), .i_out_ready(out_ready), .o_s(s2), .o_co(co2)
`ifdef CLA_PIPE_OVF_EN
        , .o_ovf(ovf2)
`endif
    );

    cla_pipe_addsub #(.WIDTH(64), .STAGES(4)) dut4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy4),
        .i_a(a64), .i_b(b64), .i_ci(ci), .i_sub(sub),
        .o_out_valid(ov4), .i_out_ready(out_ready), .o_s(s4), .o_co(co4)
`ifdef CLA_PIPE_OVF_EN
        , .o_ovf(ovf4)
`endif
    );

    cla_pipe_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
        .i_a(a), .i_b(b), .i_ci(ci), .i_sub(sub),
        .o_out_valid(ov1), .i_out_ready(out_ready), .o_s(s1), .o_co(co1)
`ifdef CLA_PIPE_OVF_EN
        , .o_ovf(ovf1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", ov2); end
        total++; if (s2 !== 32'h0) begin bad++; $display("FAIL reset_s got=%h want=00000000", s2); end
        total++; if (co2 !== 1'b0) begin bad++; $display("FAIL reset_co got=%0b want=0", co2); end
        total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", rdy2); end
        total++; if ({ov4, ov1} !== 2'b00) begin bad++; $display("FAIL reset_out_valid_w64_s1 got=%b want=00", {ov4, ov1}); end
`ifdef CLA_PIPE_OVF_EN
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf2); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int l2, l4, l1, n2;
        l2 = -1; l4 = -1; l1 = -1; n2 = 0;
        total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL lat_in_ready got=%0b want=1", rdy2); end
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h0; a64 = 64'hFFFFFFFFFFFFFFFF; b64 = '0; ci = 1'b1; sub = 1'b0;
        tick();
        in_valid = 1'b0; ci = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (ov2) n2++;
            if (ov2 && l2 < 0) begin
                l2 = e;
                total++; if ({co2, s2} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wrap_w32_s2 got=%0b_%h want=1_00000000", co2, s2); end
            end
            if (ov4 && l4 < 0) begin
                l4 = e;
                total++; if ({co4, s4} !== {1'b1, 64'h0}) begin bad++; $display("FAIL wrap_w64_s4 got=%0b_%h want=1_0000000000000000", co4, s4); end
            end
            if (ov1 && l1 < 0) begin
                l1 = e;
                total++; if ({co1, s1} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wrap_w32_s1 got=%0b_%h want=1_00000000", co1, s1); end
            end
        end
        total++; if (l2 != 3) begin bad++; $display("FAIL latency_s2 got=%0d want=3", l2); end
        total++; if (l4 != 5) begin bad++; $display("FAIL latency_s4 got=%0d want=5", l4); end
        total++; if (l1 != 2) begin bad++; $display("FAIL latency_s1 got=%0d want=2", l1); end
        total++; if (n2 != 1) begin bad++; $display("FAIL latency_valid_cycles got=%0d want=1", n2); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; a = 32'h0000FFFF; b = 32'hFFFF0000; ci = 1'b0; sub = 1'b0;
        tick();
        a = 32'h135FA562; b = 32'h35614642;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        total++; if ({ov2, co2, s2} !== {1'b1, 1'b0, 32'hFFFFFFFF}) begin bad++; $display("FAIL b2b_first got=%0b_%0b_%h want=1_0_ffffffff", ov2, co2, s2); end
        tick();
        total++; if ({ov2, co2, s2} !== {1'b1, 1'b0, 32'h48C0EBA4}) begin bad++; $display("FAIL b2b_second got=%0b_%0b_%h want=1_0_48c0eba4", ov2, co2, s2); end
        tick();
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b want=0", ov2); end
    endtask

    task automatic test_sub();
        in_valid = 1'b1; a = 32'h5; b = 32'h7; ci = 1'b1; sub = 1'b1;
        tick();
        a = 32'h7; b = 32'h5; ci = 1'b0;
        tick();
        in_valid = 1'b0; sub = 1'b0;
        repeat (2) tick();
        total++; if ({ov2, co2, s2} !== {1'b1, 1'b0, 32'hFFFFFFFE}) begin bad++; $display("FAIL sub_borrow got=%0b_%0b_%h want=1_0_fffffffe", ov2, co2, s2); end
        tick();
        total++; if ({ov2, co2, s2} !== {1'b1, 1'b1, 32'h00000002}) begin bad++; $display("FAIL sub_noborrow got=%0b_%0b_%h want=1_1_00000002", ov2, co2, s2); end
        tick();
    endtask

`ifdef CLA_PIPE_OVF_EN
    task automatic test_ovf();
        in_valid = 1'b1; a = 32'h7FFFFFFF; b = 32'h1; ci = 1'b0; sub = 1'b0;
        tick();
        a = 32'h80000000; b = 32'h1; sub = 1'b1;
        tick();
        a = 32'h3; b = 32'h4; sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if ({ov2, ovf2, co2, s2} !== {1'b1, 1'b1, 1'b0, 32'h80000000}) begin bad++; $display("FAIL ovf_add got=%0b_%0b_%0b_%h want=1_1_0_80000000", ov2, ovf2, co2, s2); end
        tick();
        total++; if ({ov2, ovf2, co2, s2} !== {1'b1, 1'b1, 1'b1, 32'h7FFFFFFF}) begin bad++; $display("FAIL ovf_sub got=%0b_%0b_%0b_%h want=1_1_1_7fffffff", ov2, ovf2, co2, s2); end
        tick();
        total++; if ({ov2, ovf2, co2, s2} !== {1'b1, 1'b0, 1'b0, 32'h00000007}) begin bad++; $display("FAIL ovf_none got=%0b_%0b_%0b_%h want=1_0_0_00000007", ov2, ovf2, co2, s2); end
        tick();
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic        tc [7];
        logic        tsb [7];
        logic [31:0] es [6];
        logic        ec [6];
        logic [31:0] h_s;
        logic        h_co;
        logic        held, acc;
        int          sent, got, cyc;
        ta = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h00000010, 32'h80000000, 32'h00000000, 32'h0};
        tb = '{32'h00000002, 32'h00000001, 32'h11111111, 32'h00000001, 32'h80000000, 32'h00000001, 32'h0};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tsb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        es = '{32'h00000003, 32'h00000000, 32'h2345678A, 32'h0000000F, 32'h00000000, 32'hFFFFFFFF};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sent = 0; got = 0; cyc = 0; held = 1'b0; h_s = '0; h_co = 1'b0;
        while (got < 6 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid = (sent < 6);
            a = ta[sent]; b = tb[sent]; ci = tc[sent]; sub = tsb[sent];
            #1;
            if (ov2 && out_ready) begin
                total++; if ({co2, s2} !== {ec[got], es[got]}) begin bad++; $display("FAIL bp_result%0d got=%0b_%h want=%0b_%h", got, co2, s2, ec[got], es[got]); end
                got++;
                held = 1'b0;
            end
            if (ov2 && !out_ready) begin
                total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b want=0", cyc, rdy2); end
                if (held) begin
                    total++; if ({co2, s2} !== {h_co, h_s}) begin bad++; $display("FAIL bp_hold cyc=%0d got=%0b_%h want=%0b_%h", cyc, co2, s2, h_co, h_s); end
                end
                held = 1'b1; h_s = s2; h_co = co2;
            end
            acc = in_valid && rdy2;
            @(posedge clk);
            if (acc) sent++;
            #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1; ci = 1'b0; sub = 1'b0;
        total++; if (got != 6 || sent != 6) begin bad++; $display("FAIL bp_count got=%0d/%0d want=6/6", got, sent); end
        repeat (6) tick();
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        in_valid = 1'b1; a = 32'h11111111; b = 32'h11111111; a64 = 64'h1; b64 = 64'h1; ci = 1'b0; sub = 1'b0;
        tick();
        a = 32'h22222222; b = 32'h1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if ({ov2, co2, s2} !== {1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL mid_reset_s2 got=%0b_%0b_%h want=0_0_00000000", ov2, co2, s2); end
        total++; if ({ov1, s1} !== {1'b0, 32'h0}) begin bad++; $display("FAIL mid_reset_s1 got=%0b_%h want=0_00000000", ov1, s1); end
        total++; if ({ov4, s4} !== {1'b0, 64'h0}) begin bad++; $display("FAIL mid_reset_s4 got=%0b_%h want=0_0000000000000000", ov4, s4); end
        total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%0b want=1", rdy2); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov2 || ov4 || ov1) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mid_reset_stale got=%0d want=0", stale); end
        in_valid = 1'b1; a = 32'h4; b = 32'h3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        total++; if ({ov1, s1} !== {1'b1, 32'h7}) begin bad++; $display("FAIL post_reset_s1 got=%0b_%h want=1_00000007", ov1, s1); end
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL post_reset_early got=%0b want=0", ov2); end
        tick();
        total++; if ({ov2, co2, s2} !== {1'b1, 1'b0, 32'h7}) begin bad++; $display("FAIL post_reset_s2 got=%0b_%0b_%h want=1_0_00000007", ov2, co2, s2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_sub();
`ifdef CLA_PIPE_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
